// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM state encoding and widths shared by the load/store unit.
package lsu_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int BE_W   = WORD_W / BYTE_W;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WB     = 2'd2;

  // Unsigned sizes only make sense for loads.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      LS_B, LS_H, LS_W: return 1'b1;
      LS_BU, LS_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory request/ready bus; master is the LSU, slave is memory.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte lanes, store replication, load extract/extend and alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [WORD_W-1:0] rs2,
  input  logic [WORD_W-1:0] rdata,
  output logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] ld_data,
  output logic              misaligned
);

  logic [WORD_W-1:0] shifted;

  always_comb begin
    shifted    = rdata >> {offset, 3'b000};
    be         = 4'b1111;
    wdata      = rs2;
    ld_data    = shifted;
    misaligned = 1'b0;
    case (funct3)
      LS_B: begin
        be      = 4'b0001 << offset;
        wdata   = {4{rs2[BYTE_W-1:0]}};
        ld_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      LS_BU: ld_data = {24'b0, shifted[7:0]};
      LS_H: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{rs2[15:0]}};
        ld_data    = {{16{shifted[15]}}, shifted[15:0]};
        misaligned = offset[0];
      end
      LS_HU: begin
        ld_data    = {16'b0, shifted[15:0]};
        misaligned = offset[0];
      end
      LS_W: misaligned = (offset != 2'b00);
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V memory-access stage: IDLE/ACCESS/WB handshake with data memory.
// Optional access watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [WORD_W-1:0] ex_addr,
  input  logic [WORD_W-1:0] ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              lsu_busy,
  load_store_unit_if.master mem,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [WORD_W-1:0] wb_data,
  output logic              exc_misaligned,
  output logic [WORD_W-1:0] exc_addr,
  output logic              exc_timeout
);

  logic [1:0]        state;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [4:0]        r_rd;
  logic [2:0]        al_f3;
  logic [1:0]        al_off;
  logic [BE_W-1:0]   al_be;
  logic [WORD_W-1:0] al_wdata;
  logic [WORD_W-1:0] al_ld;
  logic              al_mis;
  logic              accept;

  // The aligner sees the incoming op while idle and the latched op while the access is in flight.
  assign al_f3    = (state == IDLE) ? ex_funct3 : r_funct3;
  assign al_off   = (state == IDLE) ? ex_addr[1:0] : r_off;
  assign lsu_busy = (state != IDLE);
  assign accept   = (state == IDLE) && ex_valid && (ex_is_load ^ ex_is_store)
                    && f3_legal(ex_is_store, ex_funct3);

  lsu_align u_align (
    .funct3     (al_f3),
    .offset     (al_off),
    .rs2        (ex_wdata),
    .rdata      (mem.mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .ld_data    (al_ld),
    .misaligned (al_mis)
  );

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
`else
  assign exc_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      r_funct3       <= 3'b0;
      r_off          <= 2'b0;
      r_rd           <= 5'b0;
      mem.mem_req    <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_wdata  <= '0;
      mem.mem_be     <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= 5'b0;
      wb_data        <= '0;
      exc_misaligned <= 1'b0;
      exc_addr       <= '0;
`ifdef LSU_TIMEOUT_EN
      exc_timeout    <= 1'b0;
      tmo_cnt        <= 16'b0;
`endif
    end else begin
      wb_valid       <= 1'b0;
      exc_misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      exc_timeout    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept && al_mis) begin
            exc_misaligned <= 1'b1;
            exc_addr       <= ex_addr;
          end else if (accept) begin
            state         <= ACCESS;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= ex_is_store;
            mem.mem_addr  <= {ex_addr[WORD_W-1:2], 2'b00};
            mem.mem_be    <= ex_is_store ? al_be : 4'b1111;
            mem.mem_wdata <= al_wdata;
            r_funct3      <= ex_funct3;
            r_off         <= ex_addr[1:0];
            r_rd          <= ex_rd;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt       <= 16'b0;
`endif
          end
        end
        ACCESS: begin
          // A ready arriving on the timeout cycle takes priority.
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            if (mem.mem_we) begin
              state <= IDLE;
            end else begin
              state    <= WB;
              wb_valid <= 1'b1;
              wb_rd    <= r_rd;
              wb_data  <= al_ld;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            mem.mem_req <= 1'b0;
            exc_timeout <= 1'b1;
            exc_addr    <= {mem.mem_addr[WORD_W-1:2], r_off};
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with directed vectors.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_busy, wb_valid, exc_misaligned, exc_timeout;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;

  load_store_unit_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_is_load     (ex_is_load),
    .ex_is_store    (ex_is_store),
    .ex_funct3      (ex_funct3),
    .ex_addr        (ex_addr),
    .ex_wdata       (ex_wdata),
    .ex_rd          (ex_rd),
    .lsu_busy       (lsu_busy),
    .mem            (mem_bus.master),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .exc_misaligned (exc_misaligned),
    .exc_addr       (exc_addr),
    .exc_timeout    (exc_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } req_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  req_t        req_q[$];
  wb_t         wb_q[$];
  logic [31:0] exc_q[$];
  req_t        req_e;
  wb_t         wb_e;
  logic [31:0] exc_e;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a handshake, writeback or exception.
  logic        prev_req, prev_ready, prev_we;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_be;

  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (mem_bus.mem_req && mem_bus.mem_ready) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got addr 0x%08h, expected no request", mem_bus.mem_addr);
        end else begin
          req_e = req_q.pop_front();
          check("req_we", {31'b0, mem_bus.mem_we}, {31'b0, req_e.we});
          check("req_addr", mem_bus.mem_addr, req_e.addr);
          check("req_be", {28'b0, mem_bus.mem_be}, {28'b0, req_e.be});
          if (req_e.chk_wdata) check("req_wdata", mem_bus.mem_wdata, req_e.wdata);
        end
      end
      if (prev_req && !prev_ready && mem_bus.mem_req) begin
        check("req_stable_addr", mem_bus.mem_addr, prev_addr);
        check("req_stable_ctl", {27'b0, mem_bus.mem_be, mem_bus.mem_we}, {27'b0, prev_be, prev_we});
        check("req_stable_wdata", mem_bus.mem_wdata, prev_wdata);
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got rd %0d data 0x%08h, expected no writeback", wb_rd, wb_data);
        end else begin
          wb_e = wb_q.pop_front();
          check("wb_rd", {27'b0, wb_rd}, {27'b0, wb_e.rd});
          check("wb_data", wb_data, wb_e.data);
        end
      end
      if (exc_misaligned) begin
        if (exc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL exc_unexpected: got addr 0x%08h, expected no exception", exc_addr);
        end else begin
          exc_e = exc_q.pop_front();
          check("exc_addr", exc_addr, exc_e);
        end
      end
      prev_req   = mem_bus.mem_req;
      prev_ready = mem_bus.mem_ready;
      prev_we    = mem_bus.mem_we;
      prev_addr  = mem_bus.mem_addr;
      prev_wdata = mem_bus.mem_wdata;
      prev_be    = mem_bus.mem_be;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    step();
    ex_valid = 1'b0;
  endtask

  task automatic mem_respond(input int waits, input logic [31:0] rdata);
    repeat (waits) step();
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = rdata;
    step();
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [4:0] rd, input int waits, input logic [31:0] rdata,
                         input logic [31:0] exp_data);
    req_q.push_back('{1'b0, exp_addr, 4'b1111, 32'h0, 1'b0});
    wb_q.push_back('{rd, exp_data});
    present(1'b1, 1'b0, f3, addr, 32'h0, rd);
    check("load_busy_t1", {31'b0, lsu_busy}, 32'd1);
    check("load_req_t1", {31'b0, mem_bus.mem_req}, 32'd1);
    mem_respond(waits, rdata);
    check("load_wb_latency", {31'b0, wb_valid}, 32'd1);
    check("load_busy_wb", {31'b0, lsu_busy}, 32'd1);
    step();
    check("load_idle_after", {31'b0, lsu_busy}, 32'd0);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input int waits);
    req_q.push_back('{1'b1, exp_addr, exp_be, exp_wdata, 1'b1});
    present(1'b0, 1'b1, f3, addr, rs2, 5'd0);
    check("store_req_t1", {31'b0, mem_bus.mem_req}, 32'd1);
    mem_respond(waits, 32'h0);
    check("store_idle_after", {30'b0, lsu_busy, wb_valid}, 32'd0);
  endtask

  task automatic do_misaligned(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr);
    exc_q.push_back(addr);
    present(ld, st, f3, addr, 32'h5555_5555, 5'd9);
    check("mis_no_req", {30'b0, mem_bus.mem_req, lsu_busy}, 32'd0);
    step();
    check("mis_no_req_later", {30'b0, mem_bus.mem_req, lsu_busy}, 32'd0);
    check("mis_exc_addr_held", exc_addr, addr);
  endtask

  task automatic do_ignored(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr);
    present(ld, st, f3, addr, 32'h0, 5'd4);
    check("ign_no_effect", {29'b0, mem_bus.mem_req, lsu_busy, exc_misaligned}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'b0; ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {27'b0, lsu_busy, mem_bus.mem_req, wb_valid, exc_misaligned, exc_timeout}, 32'd0);
    check("rst_exc_addr", exc_addr, 32'h0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    rst = 1'b0;
    step();

    do_load(LS_B,  32'h0000_1003, 32'h0000_1000, 5'd5, 0, 32'h80FF_FF12, 32'hFFFF_FF80);
    do_load(LS_BU, 32'h0000_1003, 32'h0000_1000, 5'd6, 0, 32'h80FF_FF12, 32'h0000_0080);
    do_load(LS_H,  32'h0000_4002, 32'h0000_4000, 5'd7, 2, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load(LS_HU, 32'h0000_4000, 32'h0000_4000, 5'd8, 1, 32'h1234_F00D, 32'h0000_F00D);
    do_load(LS_W,  32'h0000_5000, 32'h0000_5000, 5'd0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    do_store(LS_H, 32'h0000_2002, 32'h1234_ABCD, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 3);
    do_store(LS_H, 32'h0000_2000, 32'h1234_ABCD, 32'h0000_2000, 4'b0011, 32'hABCD_ABCD, 0);
    do_store(LS_B, 32'h0000_6001, 32'h0000_00A5, 32'h0000_6000, 4'b0010, 32'hA5A5_A5A5, 1);
    do_store(LS_B, 32'h0000_6003, 32'hFFFF_FF3C, 32'h0000_6000, 4'b1000, 32'h3C3C_3C3C, 0);
    do_store(LS_W, 32'h0000_7000, 32'hCAFE_F00D, 32'h0000_7000, 4'b1111, 32'hCAFE_F00D, 2);

    do_misaligned(1'b1, 1'b0, LS_W,  32'h0000_3001);
    do_misaligned(1'b0, 1'b1, LS_H,  32'h0000_2001);
    do_misaligned(1'b1, 1'b0, LS_HU, 32'h0000_4003);
    do_misaligned(1'b0, 1'b1, LS_W,  32'h0000_7002);

    do_ignored(1'b1, 1'b1, LS_W,   32'h0000_8000);
    do_ignored(1'b0, 1'b1, LS_BU,  32'h0000_8000);
    do_ignored(1'b1, 1'b0, 3'b011, 32'h0000_8000);

    // Store presented while a load is in flight must wait until the unit is idle again.
    req_q.push_back('{1'b0, 32'h0000_8000, 4'b1111, 32'h0, 1'b0});
    wb_q.push_back('{5'd12, 32'h0BAD_F00D});
    req_q.push_back('{1'b1, 32'h0000_9000, 4'b1111, 32'h1122_3344, 1'b1});
    present(1'b1, 1'b0, LS_W, 32'h0000_8000, 32'h0, 5'd12);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b1;
    ex_funct3 = LS_W; ex_addr = 32'h0000_9000; ex_wdata = 32'h1122_3344; ex_rd = 5'd0;
    step();
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'h0BAD_F00D;
    step();
    mem_bus.mem_ready = 1'b0;
    check("b2b_wb_busy", {30'b0, wb_valid, lsu_busy}, 32'd3);
    step();
    check("b2b_idle", {30'b0, mem_bus.mem_req, lsu_busy}, 32'd0);
    step();
    ex_valid = 1'b0;
    check("b2b_store_issued", {30'b0, mem_bus.mem_req, mem_bus.mem_we}, 32'd3);
    mem_respond(0, 32'h0);

    // Reset in the middle of an access abandons it.
    present(1'b1, 1'b0, LS_W, 32'h0000_A000, 32'h0, 5'd3);
    step();
    #2;
    rst = 1'b1;
    mem_bus.mem_ready = 1'b1;
    #1;
    check("rst_mid_outputs", {29'b0, mem_bus.mem_req, lsu_busy, wb_valid}, 32'd0);
    check("rst_mid_addr", mem_bus.mem_addr, 32'h0);
    step();
    rst = 1'b0;
    mem_bus.mem_ready = 1'b0;
    step();
    check("rst_after_no_wb", {30'b0, wb_valid, lsu_busy}, 32'd0);
    do_load(LS_B, 32'h0000_0000, 32'h0000_0000, 5'd1, 0, 32'h0000_007F, 32'h0000_007F);

`ifdef LSU_TIMEOUT_EN
    present(1'b1, 1'b0, LS_W, 32'h0000_B004, 32'h0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("tmo_req_held", {31'b0, mem_bus.mem_req}, 32'd1);
    end
    step();
    check("tmo_pulse", {29'b0, exc_timeout, mem_bus.mem_req, lsu_busy}, 32'd4);
    check("tmo_exc_addr", exc_addr, 32'h0000_B004);
    step();
    check("tmo_pulse_end", {31'b0, exc_timeout}, 32'd0);
`else
    check("tmo_tied_low", {31'b0, exc_timeout}, 32'd0);
`endif

    step();
    check("req_q_empty", req_q.size(), 32'd0);
    check("wb_q_empty", wb_q.size(), 32'd0);
    check("exc_q_empty", exc_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
